// File: rtl/up_axi_lite_bridge.sv
// Purpose: AXI4-Lite slave to up_* register bus bridge with independent read/write paths.
// Latency: valid sampled at N -> ready + up_*req at N+1; response one cycle after the ack (N+3 for 1-cycle core).
// Backpressure: one outstanding write and one outstanding read; ready held low until the response is taken.
//
// Ports
//   up_clk / up_rst         single clock, synchronous active-high reset
//   up_axi_aw* / up_axi_w*  write address and data, accepted together in one cycle
//   up_axi_b*               write response (OKAY, or SLVERR on core timeout)
//   up_axi_ar*              read address
//   up_axi_r*               read response and data (data forced to 0 outside rvalid)
//   up_wreq/up_waddr/up_wdata/up_wack   register-bus write: one-cycle request, address/data held
//   up_rreq/up_raddr/up_rdata/up_rack   register-bus read: one-cycle request, data valid with ack
//
// Byte lanes (wstrb) are ignored: every write is a full 32-bit word. The timeout counter is
// 16 bits and saturating, so TIMEOUT_CYCLES must lie in 1..65535.

module up_axi_lite_bridge #(
    parameter int AXI_ADDRESS_WIDTH = 14,
    parameter int TIMEOUT_CYCLES    = 255
) (
    input  logic                         up_clk,
    input  logic                         up_rst,

    // AXI4-Lite write address channel
    input  logic                         up_axi_awvalid,
    input  logic [15:0]                  up_axi_awaddr,
    output logic                         up_axi_awready,

    // AXI4-Lite write data channel
    input  logic                         up_axi_wvalid,
    input  logic [31:0]                  up_axi_wdata,
    input  logic [3:0]                   up_axi_wstrb,
    output logic                         up_axi_wready,

    // AXI4-Lite write response channel
    output logic                         up_axi_bvalid,
    output logic [1:0]                   up_axi_bresp,
    input  logic                         up_axi_bready,

    // AXI4-Lite read address channel
    input  logic                         up_axi_arvalid,
    input  logic [15:0]                  up_axi_araddr,
    output logic                         up_axi_arready,

    // AXI4-Lite read data channel
    output logic                         up_axi_rvalid,
    output logic [1:0]                   up_axi_rresp,
    output logic [31:0]                  up_axi_rdata,
    input  logic                         up_axi_rready,

    // register bus, write side
    output logic                         up_wreq,
    output logic [AXI_ADDRESS_WIDTH-1:0] up_waddr,
    output logic [31:0]                  up_wdata,
    input  logic                         up_wack,

    // register bus, read side
    output logic                         up_rreq,
    output logic [AXI_ADDRESS_WIDTH-1:0] up_raddr,
    input  logic [31:0]                  up_rdata,
    input  logic                         up_rack
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // The counter is cleared on entry to WAIT and reads j during the j-th WAIT cycle (first
    // WAIT cycle is the request cycle, j=0). Firing when it reads TIMEOUT_CYCLES-1 puts the
    // error response exactly TIMEOUT_CYCLES cycles after the request cycle.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT,
        W_RESP
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } r_state_t;

    w_state_t    w_state;
    r_state_t    r_state;
    logic [15:0] w_cnt;
    logic [15:0] r_cnt;

    // An ack seen in the request cycle itself belongs to nothing we issued; only acks from the
    // cycle after the request onward complete the access. up_wreq/up_rreq are registered and
    // high only during that first WAIT cycle, so they mark it.
    logic w_ack_ok;
    logic r_ack_ok;
    assign w_ack_ok = up_wack && !up_wreq;
    assign r_ack_ok = up_rack && !up_rreq;

    // Address byte-offset bits and byte strobes carry no information for word-wide registers.
    logic unused_bits;
    assign unused_bits = ^{up_axi_wstrb, up_axi_awaddr[1:0], up_axi_araddr[1:0]};

    // ------------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------------
    always_ff @(posedge up_clk) begin
        if (up_rst) begin
            w_state        <= W_IDLE;
            w_cnt          <= 16'd0;
            up_axi_awready <= 1'b0;
            up_axi_wready  <= 1'b0;
            up_axi_bvalid  <= 1'b0;
            up_axi_bresp   <= RESP_OKAY;
            up_wreq        <= 1'b0;
            up_waddr       <= '0;
            up_wdata       <= 32'd0;
        end else begin
            // ready and request are single-cycle pulses
            up_axi_awready <= 1'b0;
            up_axi_wready  <= 1'b0;
            up_wreq        <= 1'b0;

            case (w_state)
                W_IDLE: begin
                    // address and data are only taken together; a lone AW or W just waits
                    if (up_axi_awvalid && up_axi_wvalid) begin
                        up_axi_awready <= 1'b1;
                        up_axi_wready  <= 1'b1;
                        up_wreq        <= 1'b1;
                        up_waddr       <= up_axi_awaddr[AXI_ADDRESS_WIDTH+1:2];
                        up_wdata       <= up_axi_wdata;
                        w_cnt          <= 16'd0;
                        w_state        <= W_WAIT;
                    end
                end

                W_WAIT: begin
                    // ack is tested first so an ack on the timeout cycle still reports OKAY
                    if (w_ack_ok) begin
                        up_axi_bvalid <= 1'b1;
                        up_axi_bresp  <= RESP_OKAY;
                        w_state       <= W_RESP;
                    end else if (w_cnt == TIMEOUT_LAST) begin
                        up_axi_bvalid <= 1'b1;
                        up_axi_bresp  <= RESP_SLVERR;
                        w_state       <= W_RESP;
                    end
                    if (w_cnt != 16'hFFFF) begin
                        w_cnt <= w_cnt + 16'd1;
                    end
                end

                W_RESP: begin
                    // late acks from a timed-out core land here and are dropped
                    if (up_axi_bready) begin
                        up_axi_bvalid <= 1'b0;
                        up_axi_bresp  <= RESP_OKAY;
                        w_state       <= W_IDLE;
                    end
                end

                default: begin
                    w_state <= W_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------------
    always_ff @(posedge up_clk) begin
        if (up_rst) begin
            r_state        <= R_IDLE;
            r_cnt          <= 16'd0;
            up_axi_arready <= 1'b0;
            up_axi_rvalid  <= 1'b0;
            up_axi_rresp   <= RESP_OKAY;
            up_axi_rdata   <= 32'd0;
            up_rreq        <= 1'b0;
            up_raddr       <= '0;
        end else begin
            up_axi_arready <= 1'b0;
            up_rreq        <= 1'b0;

            case (r_state)
                R_IDLE: begin
                    if (up_axi_arvalid) begin
                        up_axi_arready <= 1'b1;
                        up_rreq        <= 1'b1;
                        up_raddr       <= up_axi_araddr[AXI_ADDRESS_WIDTH+1:2];
                        r_cnt          <= 16'd0;
                        r_state        <= R_WAIT;
                    end
                end

                R_WAIT: begin
                    // up_rdata is only meaningful in the ack cycle, so capture it there
                    if (r_ack_ok) begin
                        up_axi_rvalid <= 1'b1;
                        up_axi_rresp  <= RESP_OKAY;
                        up_axi_rdata  <= up_rdata;
                        r_state       <= R_RESP;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        up_axi_rvalid <= 1'b1;
                        up_axi_rresp  <= RESP_SLVERR;
                        up_axi_rdata  <= 32'd0;
                        r_state       <= R_RESP;
                    end
                    if (r_cnt != 16'hFFFF) begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                R_RESP: begin
                    // rdata returns to 0 with rvalid so stale data never lingers on the bus
                    if (up_axi_rready) begin
                        up_axi_rvalid <= 1'b0;
                        up_axi_rresp  <= RESP_OKAY;
                        up_axi_rdata  <= 32'd0;
                        r_state       <= R_IDLE;
                    end
                end

                default: begin
                    r_state <= R_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_up_axi_lite_bridge.sv
// Purpose: self-checking bench for up_axi_lite_bridge with a behavioural register core.
// Latency: expectations derived from valid-at-N / req-at-N+1 / resp-at-N+2+ack_delay.
// Backpressure: bready/rready held low for chosen periods while probing for illegal acceptance.

module tb_up_axi_lite_bridge;

    localparam int AW = 14;
    localparam int TO = 8;

    logic          up_clk = 1'b0;
    logic          up_rst;
    logic          up_axi_awvalid;
    logic [15:0]   up_axi_awaddr;
    logic          up_axi_awready;
    logic          up_axi_wvalid;
    logic [31:0]   up_axi_wdata;
    logic [3:0]    up_axi_wstrb;
    logic          up_axi_wready;
    logic          up_axi_bvalid;
    logic [1:0]    up_axi_bresp;
    logic          up_axi_bready;
    logic          up_axi_arvalid;
    logic [15:0]   up_axi_araddr;
    logic          up_axi_arready;
    logic          up_axi_rvalid;
    logic [1:0]    up_axi_rresp;
    logic [31:0]   up_axi_rdata;
    logic          up_axi_rready;
    logic          up_wreq;
    logic [AW-1:0] up_waddr;
    logic [31:0]   up_wdata;
    logic          up_wack;
    logic          up_rreq;
    logic [AW-1:0] up_raddr;
    logic [31:0]   up_rdata;
    logic          up_rack;

    always #5 up_clk = ~up_clk;

    up_axi_lite_bridge #(
        .AXI_ADDRESS_WIDTH (AW),
        .TIMEOUT_CYCLES    (TO)
    ) dut (
        .up_clk         (up_clk),
        .up_rst         (up_rst),
        .up_axi_awvalid (up_axi_awvalid),
        .up_axi_awaddr  (up_axi_awaddr),
        .up_axi_awready (up_axi_awready),
        .up_axi_wvalid  (up_axi_wvalid),
        .up_axi_wdata   (up_axi_wdata),
        .up_axi_wstrb   (up_axi_wstrb),
        .up_axi_wready  (up_axi_wready),
        .up_axi_bvalid  (up_axi_bvalid),
        .up_axi_bresp   (up_axi_bresp),
        .up_axi_bready  (up_axi_bready),
        .up_axi_arvalid (up_axi_arvalid),
        .up_axi_araddr  (up_axi_araddr),
        .up_axi_arready (up_axi_arready),
        .up_axi_rvalid  (up_axi_rvalid),
        .up_axi_rresp   (up_axi_rresp),
        .up_axi_rdata   (up_axi_rdata),
        .up_axi_rready  (up_axi_rready),
        .up_wreq        (up_wreq),
        .up_waddr       (up_waddr),
        .up_wdata       (up_wdata),
        .up_wack        (up_wack),
        .up_rreq        (up_rreq),
        .up_raddr       (up_raddr),
        .up_rdata       (up_rdata),
        .up_rack        (up_rack)
    );

    wire [102:0] all_outs = {up_axi_awready, up_axi_wready, up_axi_bvalid, up_axi_bresp,
                             up_axi_arready, up_axi_rvalid, up_axi_rresp, up_axi_rdata,
                             up_wreq, up_waddr, up_wdata, up_rreq, up_raddr};

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge up_clk) cyc <= cyc + 1;

    // core register contents and the bench's own expectation of them
    logic [31:0] core_mem [int];
    logic [31:0] exp_mem  [int];

    // responder controls
    int w_delay = 1;
    int r_delay = 1;
    bit w_ack_en = 1'b1;
    bit r_ack_en = 1'b1;
    int stray_w_req = 0;
    int stray_r_req = 0;

    // Behavioural register core: stores on every write request, acks after a chosen delay,
    // and drives random junk on up_rdata outside the ack cycle.
    initial begin : responder
        int wcnt;
        int rcnt;
        int ra;
        int stray_w_done;
        int stray_r_done;
        wcnt = 0; rcnt = 0; ra = 0; stray_w_done = 0; stray_r_done = 0;
        up_wack = 1'b0; up_rack = 1'b0; up_rdata = 32'd0;
        forever begin
            @(posedge up_clk); #1;
            up_wack = 1'b0; up_rack = 1'b0; up_rdata = $urandom;
            if (wcnt > 0) begin
                wcnt--;
                if (wcnt == 0) up_wack = 1'b1;
            end
            if (rcnt > 0) begin
                rcnt--;
                if (rcnt == 0) begin
                    up_rack  = 1'b1;
                    up_rdata = core_mem.exists(ra) ? core_mem[ra] : 32'd0;
                end
            end
            if (stray_w_done != stray_w_req) begin up_wack = 1'b1; stray_w_done = stray_w_req; end
            if (stray_r_done != stray_r_req) begin up_rack = 1'b1; stray_r_done = stray_r_req; end
            @(negedge up_clk);
            if (up_wreq) begin
                core_mem[int'(up_waddr)] = up_wdata;
                wcnt = w_ack_en ? w_delay : 0;
            end
            if (up_rreq) begin
                ra = int'(up_raddr);
                rcnt = r_ack_en ? r_delay : 0;
            end
        end
    end

    // observations from the AXI master drivers
    int wt_rdy, wt_resp, wn_req, w_req_cyc;
    logic [1:0] w_resp;
    logic [AW-1:0] w_req_addr;
    logic [31:0] w_req_data;
    bit w_clean;
    int rt_rdy, rt_resp, rn_req, r_req_cyc;
    logic [1:0] r_resp;
    logic [AW-1:0] r_req_addr;
    logic [31:0] r_rdata_obs;
    bit r_clean;

    // Cycle indices k count negedges after the edge that first samples valid (k=1 is cycle N+1).
    // hold>0 keeps bready low that many cycles after bvalid while a second write is offered.
    task automatic axi_write(input logic [15:0] addr, input logic [31:0] data, input int hold);
        int k;
        k = 0; wt_rdy = -1; wt_resp = -1; wn_req = 0; w_req_cyc = -1;
        w_resp = 2'b11; w_req_addr = '0; w_req_data = '0; w_clean = 1'b1;
        @(negedge up_clk);
        up_axi_awaddr = addr; up_axi_wdata = data; up_axi_wstrb = 4'($urandom);
        up_axi_awvalid = 1'b1; up_axi_wvalid = 1'b1; up_axi_bready = (hold == 0);
        while (wt_resp < 0 && k < 200) begin
            @(negedge up_clk); k++;
            if (up_wreq) begin wn_req++; w_req_addr = up_waddr; w_req_data = up_wdata; w_req_cyc = cyc; end
            if (up_axi_bvalid) begin wt_resp = k; w_resp = up_axi_bresp; end
            if (up_axi_awready && up_axi_wready && wt_rdy < 0) begin
                wt_rdy = k;
                @(posedge up_clk); #1;
                up_axi_awvalid = 1'b0; up_axi_wvalid = 1'b0;
            end else if (up_axi_awready || up_axi_wready) begin
                w_clean = 1'b0;
            end
        end
        if (wt_resp >= 0) begin
            for (int i = 0; i < hold; i++) begin
                up_axi_awvalid = 1'b1; up_axi_wvalid = 1'b1;
                @(negedge up_clk);
                if (!up_axi_bvalid || up_axi_bresp !== w_resp || up_axi_awready || up_axi_wready || up_wreq)
                    w_clean = 1'b0;
            end
            up_axi_awvalid = 1'b0; up_axi_wvalid = 1'b0; up_axi_bready = 1'b1;
            @(negedge up_clk);
            if (up_axi_bvalid || up_wreq || up_axi_awready) w_clean = 1'b0;
        end
        up_axi_awvalid = 1'b0; up_axi_wvalid = 1'b0; up_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [15:0] addr, input int hold);
        int k;
        k = 0; rt_rdy = -1; rt_resp = -1; rn_req = 0; r_req_cyc = -1;
        r_resp = 2'b11; r_req_addr = '0; r_rdata_obs = 32'hDEAD_BEEF; r_clean = 1'b1;
        @(negedge up_clk);
        up_axi_araddr = addr; up_axi_arvalid = 1'b1; up_axi_rready = (hold == 0);
        while (rt_resp < 0 && k < 200) begin
            @(negedge up_clk); k++;
            if (up_rreq) begin rn_req++; r_req_addr = up_raddr; r_req_cyc = cyc; end
            if (up_axi_rvalid) begin rt_resp = k; r_resp = up_axi_rresp; r_rdata_obs = up_axi_rdata; end
            else if (up_axi_rdata !== 32'd0) r_clean = 1'b0;
            if (up_axi_arready && rt_rdy < 0) begin
                rt_rdy = k;
                @(posedge up_clk); #1;
                up_axi_arvalid = 1'b0;
            end else if (up_axi_arready) begin
                r_clean = 1'b0;
            end
        end
        if (rt_resp >= 0) begin
            for (int i = 0; i < hold; i++) begin
                up_axi_arvalid = 1'b1;
                @(negedge up_clk);
                if (!up_axi_rvalid || up_axi_rresp !== r_resp || up_axi_rdata !== r_rdata_obs ||
                    up_axi_arready || up_rreq)
                    r_clean = 1'b0;
            end
            up_axi_arvalid = 1'b0; up_axi_rready = 1'b1;
            @(negedge up_clk);
            if (up_axi_rvalid || up_rreq || up_axi_arready || up_axi_rdata !== 32'd0) r_clean = 1'b0;
        end
        up_axi_arvalid = 1'b0; up_axi_rready = 1'b0;
    endtask

    task automatic test_reset();
        up_axi_awvalid = 1'b1; up_axi_wvalid = 1'b1; up_axi_arvalid = 1'b1;
        up_axi_awaddr = 16'h0010; up_axi_araddr = 16'h0010; up_axi_wdata = 32'h1;
        repeat (3) @(negedge up_clk);
        checks++;
        if (all_outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", all_outs); end
        up_axi_awvalid = 1'b0; up_axi_wvalid = 1'b0; up_axi_arvalid = 1'b0;
        up_rst = 1'b0;
        @(negedge up_clk);
        checks++;
        if (all_outs !== '0) begin errors++; $display("FAIL idle_after_reset: got %h want 0", all_outs); end
    endtask

    task automatic test_write_basic();
        w_delay = 1; w_ack_en = 1'b1;
        axi_write(16'h0008, 32'hA5A5_0001, 0);
        exp_mem[2] = 32'hA5A5_0001;
        checks++; if (wt_rdy !== 1) begin errors++; $display("FAIL wr_ready_lat: got %0d want 1", wt_rdy); end
        checks++; if (wn_req !== 1) begin errors++; $display("FAIL wr_req_pulses: got %0d want 1", wn_req); end
        checks++; if (w_req_addr !== 14'd2) begin errors++; $display("FAIL wr_waddr: got %0d want 2", w_req_addr); end
        checks++; if (w_req_data !== 32'hA5A5_0001) begin errors++; $display("FAIL wr_wdata: got %h want a5a50001", w_req_data); end
        checks++; if (wt_resp !== 3) begin errors++; $display("FAIL wr_bvalid_lat: got %0d want 3", wt_resp); end
        checks++; if (w_resp !== 2'b00) begin errors++; $display("FAIL wr_bresp: got %b want 00", w_resp); end
        checks++; if (!w_clean) begin errors++; $display("FAIL wr_protocol: got unclean want clean"); end
    endtask

    task automatic test_read_basic();
        core_mem[3] = 32'h5359_4944; exp_mem[3] = 32'h5359_4944;
        r_delay = 1; r_ack_en = 1'b1;
        axi_read(16'h000C, 0);
        checks++; if (rt_rdy !== 1) begin errors++; $display("FAIL rd_ready_lat: got %0d want 1", rt_rdy); end
        checks++; if (rn_req !== 1) begin errors++; $display("FAIL rd_req_pulses: got %0d want 1", rn_req); end
        checks++; if (r_req_addr !== 14'd3) begin errors++; $display("FAIL rd_raddr: got %0d want 3", r_req_addr); end
        checks++; if (rt_resp !== 3) begin errors++; $display("FAIL rd_rvalid_lat: got %0d want 3", rt_resp); end
        checks++; if (r_resp !== 2'b00) begin errors++; $display("FAIL rd_rresp: got %b want 00", r_resp); end
        checks++; if (r_rdata_obs !== 32'h5359_4944) begin errors++; $display("FAIL rd_rdata: got %h want 53594944", r_rdata_obs); end
        checks++; if (!r_clean) begin errors++; $display("FAIL rd_protocol: got unclean want clean"); end
    endtask

    task automatic test_timeout();
        bit quiet;
        // read with dead core: SLVERR TO cycles after the request cycle
        r_ack_en = 1'b0;
        axi_read(16'h0010, 0);
        checks++; if (rt_resp !== 1 + TO) begin errors++; $display("FAIL rd_timeout_lat: got %0d want %0d", rt_resp, 1 + TO); end
        checks++; if (r_resp !== 2'b10) begin errors++; $display("FAIL rd_timeout_resp: got %b want 10", r_resp); end
        checks++; if (r_rdata_obs !== 32'd0) begin errors++; $display("FAIL rd_timeout_data: got %h want 0", r_rdata_obs); end
        stray_r_req++;
        quiet = 1'b1;
        repeat (4) begin
            @(negedge up_clk);
            if (up_axi_rvalid || up_axi_rdata !== 32'd0) quiet = 1'b0;
        end
        checks++; if (!quiet) begin errors++; $display("FAIL rd_late_ack: got response want none"); end
        r_ack_en = 1'b1; r_delay = 1;
        axi_read(16'h000C, 0);
        checks++; if (rt_resp !== 3 || r_resp !== 2'b00 || r_rdata_obs !== 32'h5359_4944) begin
            errors++; $display("FAIL rd_after_timeout: got lat %0d resp %b data %h want 3 00 53594944", rt_resp, r_resp, r_rdata_obs);
        end
        // write with dead core
        w_ack_en = 1'b0;
        axi_write(16'h0014, 32'h0BAD_0005, 0);
        exp_mem[5] = 32'h0BAD_0005;
        checks++; if (wt_resp !== 1 + TO || w_resp !== 2'b10) begin
            errors++; $display("FAIL wr_timeout: got lat %0d resp %b want %0d 10", wt_resp, w_resp, 1 + TO);
        end
        // ack on the timeout cycle itself still reports OKAY; one cycle later is too late
        w_ack_en = 1'b1; w_delay = TO - 1;
        axi_write(16'h0018, 32'h0600_0006, 0);
        exp_mem[6] = 32'h0600_0006;
        checks++; if (wt_resp !== 1 + TO || w_resp !== 2'b00) begin
            errors++; $display("FAIL wr_ack_at_timeout: got lat %0d resp %b want %0d 00", wt_resp, w_resp, 1 + TO);
        end
        w_delay = TO;
        axi_write(16'h001C, 32'h0700_0007, 0);
        exp_mem[7] = 32'h0700_0007;
        checks++; if (wt_resp !== 1 + TO || w_resp !== 2'b10) begin
            errors++; $display("FAIL wr_ack_after_timeout: got lat %0d resp %b want %0d 10", wt_resp, w_resp, 1 + TO);
        end
        w_delay = 1;
        repeat (2) @(negedge up_clk);
    endtask

    task automatic test_backpressure();
        w_delay = 2; r_delay = 1;
        axi_write(16'h0024, 32'hCAFE_0009, 20);
        exp_mem[9] = 32'hCAFE_0009;
        checks++; if (wt_resp !== 4 || w_resp !== 2'b00) begin errors++; $display("FAIL bp_wr_resp: got lat %0d resp %b want 4 00", wt_resp, w_resp); end
        checks++; if (!w_clean || wn_req !== 1) begin errors++; $display("FAIL bp_wr_stable: got clean %0d reqs %0d want 1 1", w_clean, wn_req); end
        axi_read(16'h0024, 20);
        checks++; if (r_rdata_obs !== 32'hCAFE_0009 || r_resp !== 2'b00) begin errors++; $display("FAIL bp_rd_resp: got %h %b want cafe0009 00", r_rdata_obs, r_resp); end
        checks++; if (!r_clean || rn_req !== 1) begin errors++; $display("FAIL bp_rd_stable: got clean %0d reqs %0d want 1 1", r_clean, rn_req); end
        w_delay = 1;
    endtask

    task automatic test_concurrent();
        logic [31:0] d0, d2;
        d0 = $urandom; d2 = $urandom;
        core_mem[0] = d0; exp_mem[0] = d0;
        w_delay = 1; r_delay = 1;
        fork
            axi_write(16'h0008, d2, 0);
            axi_read(16'h0000, 0);
        join
        exp_mem[2] = d2;
        checks++; if (w_req_cyc !== r_req_cyc || w_req_cyc < 0) begin errors++; $display("FAIL conc_req_cycle: got w %0d r %0d want equal", w_req_cyc, r_req_cyc); end
        checks++; if (wt_resp !== 3 || w_resp !== 2'b00 || w_req_addr !== 14'd2) begin errors++; $display("FAIL conc_wr: got lat %0d resp %b addr %0d want 3 00 2", wt_resp, w_resp, w_req_addr); end
        checks++; if (rt_resp !== 3 || r_resp !== 2'b00 || r_rdata_obs !== d0) begin errors++; $display("FAIL conc_rd: got lat %0d resp %b data %h want 3 00 %h", rt_resp, r_resp, r_rdata_obs, d0); end
    endtask

    task automatic test_reset_mid();
        bit quiet;
        logic [31:0] v;
        w_ack_en = 1'b0; r_ack_en = 1'b0;
        @(negedge up_clk);
        up_axi_awaddr = 16'h0020; up_axi_wdata = 32'h8000_0001; up_axi_araddr = 16'h0024;
        up_axi_awvalid = 1'b1; up_axi_wvalid = 1'b1; up_axi_arvalid = 1'b1;
        @(negedge up_clk);
        checks++; if (!(up_wreq && up_rreq)) begin errors++; $display("FAIL rst_mid_reqs: got %b%b want 11", up_wreq, up_rreq); end
        @(posedge up_clk); #1;
        up_axi_awvalid = 1'b0; up_axi_wvalid = 1'b0; up_axi_arvalid = 1'b0;
        exp_mem[8] = 32'h8000_0001;
        @(negedge up_clk);
        up_rst = 1'b1;
        @(negedge up_clk);
        checks++; if (all_outs !== '0) begin errors++; $display("FAIL rst_mid_outputs: got %h want 0", all_outs); end
        up_rst = 1'b0;
        w_ack_en = 1'b1; r_ack_en = 1'b1; w_delay = 1; r_delay = 1;
        stray_w_req++; stray_r_req++;
        quiet = 1'b1;
        repeat (6) begin
            @(negedge up_clk);
            if (all_outs[102:34] !== '0 || up_wreq || up_rreq) quiet = 1'b0;
        end
        checks++; if (!quiet) begin errors++; $display("FAIL rst_late_ack: got activity want none"); end
        v = $urandom;
        axi_write(16'h0008, v, 0);
        exp_mem[2] = v;
        axi_read(16'h0008, 0);
        checks++; if (w_resp !== 2'b00 || r_resp !== 2'b00 || r_rdata_obs !== v) begin
            errors++; $display("FAIL rst_fresh_rw: got %b %b %h want 00 00 %h", w_resp, r_resp, r_rdata_obs, v);
        end
    endtask

    // Random mix of single reads/writes over 16 words with random ack delay, dead-core
    // accesses and short response backpressure.
    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int word;
            int d;
            int hold;
            int exp_t;
            bit en;
            bit ok;
            logic [15:0] addr;
            logic [31:0] data;
            logic [31:0] exp_d;
            word = $urandom_range(0, 15);
            addr = 16'(word * 4 + $urandom_range(0, 3));
            d = $urandom_range(1, TO);
            en = ($urandom_range(0, 7) != 0);
            hold = $urandom_range(0, 3);
            ok = en && (d <= TO - 1);
            exp_t = ok ? 2 + d : 1 + TO;
            if ($urandom_range(0, 1) == 1) begin
                data = $urandom;
                w_delay = d; w_ack_en = en;
                axi_write(addr, data, hold);
                exp_mem[word] = data;
                checks++;
                if (wt_resp !== exp_t || w_resp !== (ok ? 2'b00 : 2'b10) || wn_req !== 1 ||
                    w_req_addr !== AW'(word) || w_req_data !== data || !w_clean) begin
                    errors++;
                    $display("FAIL rand_wr[%0d]: got lat %0d resp %b reqs %0d addr %0d data %h clean %0d want %0d %b 1 %0d %h 1",
                             n, wt_resp, w_resp, wn_req, w_req_addr, w_req_data, w_clean, exp_t, ok ? 2'b00 : 2'b10, word, data);
                end
            end else begin
                r_delay = d; r_ack_en = en;
                axi_read(addr, hold);
                exp_d = (ok && exp_mem.exists(word)) ? exp_mem[word] : 32'd0;
                checks++;
                if (rt_resp !== exp_t || r_resp !== (ok ? 2'b00 : 2'b10) || rn_req !== 1 ||
                    r_req_addr !== AW'(word) || r_rdata_obs !== exp_d || !r_clean) begin
                    errors++;
                    $display("FAIL rand_rd[%0d]: got lat %0d resp %b reqs %0d addr %0d data %h clean %0d want %0d %b 1 %0d %h 1",
                             n, rt_resp, r_resp, rn_req, r_req_addr, r_rdata_obs, r_clean, exp_t, ok ? 2'b00 : 2'b10, word, exp_d);
                end
            end
            repeat (2) @(negedge up_clk);
        end
        w_delay = 1; r_delay = 1; w_ack_en = 1'b1; r_ack_en = 1'b1;
    endtask

    initial begin
        up_rst = 1'b1;
        up_axi_awvalid = 1'b0; up_axi_awaddr = 16'd0;
        up_axi_wvalid = 1'b0; up_axi_wdata = 32'd0; up_axi_wstrb = 4'd0;
        up_axi_bready = 1'b0;
        up_axi_arvalid = 1'b0; up_axi_araddr = 16'd0;
        up_axi_rready = 1'b0;
        test_reset();
        test_write_basic();
        test_read_basic();
        test_timeout();
        test_backpressure();
        test_concurrent();
        test_reset_mid();
        test_random();
        repeat (3) @(negedge up_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1);
    end

endmodule
